// File: rtl/iiitb_usr_ser_tx.sv
// Parallel-to-serial word transmitter feeding the serial/select inputs of a
// remote universal shift register, MSB-first (shift-left) or LSB-first (shift-right).
module iiitb_usr_ser_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    input  logic                         dir,
    output logic                         ser_out,
    output logic [1:0]                   sel_out,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

    localparam int CW       = $clog2(WIDTH + 1);
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic              dir_q, dir_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic              ser_q, ser_d;
    logic [1:0]        sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            dir_q     <= 1'b0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            ser_q     <= 1'b0;
            sel_q     <= 2'b11;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            dir_q     <= dir_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ser_q     <= ser_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        dir_d     = dir_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ser_d     = 1'b0;
        sel_d     = 2'b11;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (tx_valid) begin
                    shreg_d = tx_data;
                    dir_d   = dir;
                    state_d = ST_SHIFT;
                    ser_d   = dir ? tx_data[0] : tx_data[WIDTH-1];
                    sel_d   = {1'b0, dir};
                end
            end
            ST_SHIFT: begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                sel_d     = {1'b0, dir_q};
                // ser_out always shows the bit adjacent to the one just sampled.
                if (dir_q) begin
                    shreg_d = shreg_q >> 1;
                    ser_d   = shreg_q[1];
                end else begin
                    shreg_d = shreg_q << 1;
                    ser_d   = shreg_q[WIDTH-2];
                end
                if (bit_cnt_q == CW'(WIDTH - 1)) begin
                    done_d    = 1'b1;
                    sel_d     = 2'b11;
                    ser_d     = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == 4'(GAP_LAST)) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign ser_out  = ser_q;
    assign sel_out  = sel_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_iiitb_usr_ser_tx.sv
// Directed bench: three transmitters (GAP = 1, 0, 3) each feeding a model
// universal shift register that follows sel_out/ser_out.
module tb_iiitb_usr_ser_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [7:0]      tx_data;
    logic            dir;
    logic [2:0]      tx_valid;
    logic [2:0]      tx_ready;
    logic [2:0]      ser;
    logic [2:0]      busy;
    logic [2:0]      done;
    logic [2:0][1:0] sel;
    logic [2:0][3:0] bc;
    logic [2:0][7:0] rx;

    int checks   = 0;
    int failures = 0;

    iiitb_usr_ser_tx #(.WIDTH(8), .GAP(1)) u_gap1 (
        .clock(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .dir(dir), .ser_out(ser[0]), .sel_out(sel[0]),
        .busy(busy[0]), .done(done[0]), .bit_cnt(bc[0])
    );
    iiitb_usr_ser_tx #(.WIDTH(8), .GAP(0)) u_gap0 (
        .clock(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .dir(dir), .ser_out(ser[1]), .sel_out(sel[1]),
        .busy(busy[1]), .done(done[1]), .bit_cnt(bc[1])
    );
    iiitb_usr_ser_tx #(.WIDTH(8), .GAP(3)) u_gap3 (
        .clock(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .dir(dir), .ser_out(ser[2]), .sel_out(sel[2]),
        .busy(busy[2]), .done(done[2]), .bit_cnt(bc[2])
    );

    // Receiving universal shift registers on the same clock.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset)
                rx[i] <= 8'h00;
            else if (sel[i] == 2'b00)
                rx[i] <= {rx[i][6:0], ser[i]};
            else if (sel[i] == 2'b01)
                rx[i] <= {ser[i], rx[i][7:1]};
        end
    end

    // Called at a negedge with the unit idle; returns at the negedge where bit 0 is shown.
    task automatic send(input int u, input logic [7:0] d, input logic dr);
        tx_data     = d;
        dir         = dr;
        tx_valid[u] = 1'b1;
        @(negedge clk);
        tx_valid[u] = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        tx_valid = 3'b000;
        tx_data  = 8'h00;
        dir      = 1'b0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++; if (sel[u] !== 2'b11) begin failures++; $display("FAIL reset_sel u%0d: got %b expected 11", u, sel[u]); end
            checks++; if (ser[u] !== 1'b0) begin failures++; $display("FAIL reset_ser u%0d: got %b expected 0", u, ser[u]); end
            checks++; if (busy[u] !== 1'b0) begin failures++; $display("FAIL reset_busy u%0d: got %b expected 0", u, busy[u]); end
            checks++; if (done[u] !== 1'b0) begin failures++; $display("FAIL reset_done u%0d: got %b expected 0", u, done[u]); end
            checks++; if (bc[u] !== 4'd0) begin failures++; $display("FAIL reset_bitcnt u%0d: got %0d expected 0", u, bc[u]); end
            checks++; if (tx_ready[u] !== 1'b1) begin failures++; $display("FAIL reset_ready u%0d: got %b expected 1", u, tx_ready[u]); end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_msb_first();
        logic [7:0] w;
        w = 8'hA5;
        send(0, w, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++; if (ser[0] !== w[7-i]) begin failures++; $display("FAIL msb_ser bit%0d: got %b expected %b", i, ser[0], w[7-i]); end
            checks++; if (sel[0] !== 2'b00) begin failures++; $display("FAIL msb_sel bit%0d: got %b expected 00", i, sel[0]); end
            checks++; if (bc[0] !== 4'(i)) begin failures++; $display("FAIL msb_bitcnt bit%0d: got %0d expected %0d", i, bc[0], i); end
            checks++; if (done[0] !== 1'b0) begin failures++; $display("FAIL msb_early_done bit%0d: got %b expected 0", i, done[0]); end
            @(negedge clk);
        end
        checks++; if (done[0] !== 1'b1) begin failures++; $display("FAIL msb_done: got %b expected 1", done[0]); end
        checks++; if (sel[0] !== 2'b11) begin failures++; $display("FAIL msb_gap_sel: got %b expected 11", sel[0]); end
        checks++; if (ser[0] !== 1'b0) begin failures++; $display("FAIL msb_gap_ser: got %b expected 0", ser[0]); end
        checks++; if (bc[0] !== 4'd8) begin failures++; $display("FAIL msb_bitcnt_done: got %0d expected 8", bc[0]); end
        checks++; if (rx[0] !== 8'hA5) begin failures++; $display("FAIL msb_rx: got %h expected a5", rx[0]); end
        checks++; if (tx_ready[0] !== 1'b0) begin failures++; $display("FAIL msb_gap_ready: got %b expected 0", tx_ready[0]); end
        checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL msb_gap_busy: got %b expected 1", busy[0]); end
        @(negedge clk);
        checks++; if (done[0] !== 1'b0) begin failures++; $display("FAIL msb_done_len: got %b expected 0", done[0]); end
        checks++; if (tx_ready[0] !== 1'b1) begin failures++; $display("FAIL msb_ready_rise: got %b expected 1", tx_ready[0]); end
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL msb_idle_busy: got %b expected 0", busy[0]); end
        checks++; if (bc[0] !== 4'd0) begin failures++; $display("FAIL msb_idle_bitcnt: got %0d expected 0", bc[0]); end
        $display("msb_first word=a5 rx=%h", rx[0]);
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        w = 8'h3C;
        send(0, w, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checks++; if (ser[0] !== w[i]) begin failures++; $display("FAIL lsb_ser bit%0d: got %b expected %b", i, ser[0], w[i]); end
            checks++; if (sel[0] !== 2'b01) begin failures++; $display("FAIL lsb_sel bit%0d: got %b expected 01", i, sel[0]); end
            checks++; if (bc[0] !== 4'(i)) begin failures++; $display("FAIL lsb_bitcnt bit%0d: got %0d expected %0d", i, bc[0], i); end
            @(negedge clk);
        end
        checks++; if (done[0] !== 1'b1) begin failures++; $display("FAIL lsb_done: got %b expected 1", done[0]); end
        checks++; if (bc[0] !== 4'd8) begin failures++; $display("FAIL lsb_bitcnt_done: got %0d expected 8", bc[0]); end
        checks++; if (rx[0] !== 8'h3C) begin failures++; $display("FAIL lsb_rx: got %h expected 3c", rx[0]); end
        @(negedge clk);
        $display("lsb_first word=3c rx=%h", rx[0]);
    endtask

    task automatic test_back_to_back();
        logic [7:0] w1;
        logic       exp_ser;
        logic [1:0] exp_sel;
        logic       exp_done;
        w1          = 8'h01;
        tx_data     = w1;
        dir         = 1'b0;
        tx_valid[1] = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            exp_done = (n == 9) || (n == 18);
            exp_sel  = (n == 9 || n == 18) ? 2'b11 : 2'b00;
            exp_ser  = (n <= 8) ? w1[8-n] : ((n >= 10 && n <= 17) ? 1'b1 : 1'b0);
            checks++; if (ser[1] !== exp_ser) begin failures++; $display("FAIL b2b_ser n%0d: got %b expected %b", n, ser[1], exp_ser); end
            checks++; if (sel[1] !== exp_sel) begin failures++; $display("FAIL b2b_sel n%0d: got %b expected %b", n, sel[1], exp_sel); end
            checks++; if (done[1] !== exp_done) begin failures++; $display("FAIL b2b_done n%0d: got %b expected %b", n, done[1], exp_done); end
            if (n == 9) begin
                checks++; if (rx[1] !== 8'h01) begin failures++; $display("FAIL b2b_rx1: got %h expected 01", rx[1]); end
                checks++; if (tx_ready[1] !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b expected 1", tx_ready[1]); end
            end
            if (n == 18) begin
                checks++; if (rx[1] !== 8'hFF) begin failures++; $display("FAIL b2b_rx2: got %h expected ff", rx[1]); end
            end
            if (n == 1)  tx_data = 8'hFF;
            if (n == 10) tx_data = 8'h00;
            if (n == 18) tx_valid[1] = 1'b0;
        end
        @(negedge clk);
        $display("back_to_back words=01,ff rx=%h", rx[1]);
    endtask

    task automatic test_mid_word_change();
        logic [7:0] w;
        w = 8'hC6;
        send(0, w, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++; if (ser[0] !== w[7-i]) begin failures++; $display("FAIL midchg_ser bit%0d: got %b expected %b", i, ser[0], w[7-i]); end
            checks++; if (sel[0] !== 2'b00) begin failures++; $display("FAIL midchg_sel bit%0d: got %b expected 00", i, sel[0]); end
            tx_data = ~tx_data;
            dir     = ~dir;
            @(negedge clk);
        end
        checks++; if (rx[0] !== 8'hC6) begin failures++; $display("FAIL midchg_rx: got %h expected c6", rx[0]); end
        @(negedge clk);
        $display("mid_word_change word=c6 rx=%h", rx[0]);
    endtask

    task automatic test_reset_abort();
        int done_seen;
        send(0, 8'hF0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (sel[0] !== 2'b11) begin failures++; $display("FAIL abort_sel: got %b expected 11", sel[0]); end
        checks++; if (ser[0] !== 1'b0) begin failures++; $display("FAIL abort_ser: got %b expected 0", ser[0]); end
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy[0]); end
        checks++; if (done[0] !== 1'b0) begin failures++; $display("FAIL abort_done: got %b expected 0", done[0]); end
        reset     = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done[0] === 1'b1) done_seen++;
        end
        checks++; if (done_seen != 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_seen); end
        send(0, 8'h81, 1'b0);
        repeat (8) @(negedge clk);
        checks++; if (done[0] !== 1'b1) begin failures++; $display("FAIL abort_next_done: got %b expected 1", done[0]); end
        checks++; if (rx[0] !== 8'h81) begin failures++; $display("FAIL abort_next_rx: got %h expected 81", rx[0]); end
        @(negedge clk);
        $display("reset_abort word=f0 then 81 rx=%h", rx[0]);
    endtask

    task automatic test_gap3();
        send(2, 8'h96, 1'b1);
        repeat (8) @(negedge clk);
        checks++; if (done[2] !== 1'b1) begin failures++; $display("FAIL gap3_done: got %b expected 1", done[2]); end
        checks++; if (rx[2] !== 8'h96) begin failures++; $display("FAIL gap3_rx: got %h expected 96", rx[2]); end
        checks++; if (tx_ready[2] !== 1'b0) begin failures++; $display("FAIL gap3_ready0: got %b expected 0", tx_ready[2]); end
        checks++; if (sel[2] !== 2'b11) begin failures++; $display("FAIL gap3_sel0: got %b expected 11", sel[2]); end
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            checks++; if (tx_ready[2] !== 1'b0) begin failures++; $display("FAIL gap3_ready%0d: got %b expected 0", k, tx_ready[2]); end
            checks++; if (sel[2] !== 2'b11) begin failures++; $display("FAIL gap3_sel%0d: got %b expected 11", k, sel[2]); end
            checks++; if (busy[2] !== 1'b1) begin failures++; $display("FAIL gap3_busy%0d: got %b expected 1", k, busy[2]); end
        end
        @(negedge clk);
        checks++; if (tx_ready[2] !== 1'b1) begin failures++; $display("FAIL gap3_ready_rise: got %b expected 1", tx_ready[2]); end
        checks++; if (busy[2] !== 1'b0) begin failures++; $display("FAIL gap3_idle_busy: got %b expected 0", busy[2]); end
        $display("gap3 word=96 rx=%h", rx[2]);
    endtask

    initial begin
        reset    = 1'b1;
        tx_valid = 3'b000;
        tx_data  = 8'h00;
        dir      = 1'b0;
        @(negedge clk);
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_mid_word_change();
        test_reset_abort();
        test_gap3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iiitb_usr_ser_tx.md
Name: iiitb_usr_ser_tx

Overview:
Parallel-to-serial word transmitter that drives the serial/select inputs of a remote universal shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Emits the word one bit per clock on ser_out, with a matching select code on sel_out, so a receiving shift register captures it in exactly WIDTH clocks.
- Supports MSB-first (receiver shift-left) and LSB-first (receiver shift-right) modes.
- Sits between the management/IO side and any shift-register receiver in the user area.

Parameters:
WIDTH, 8, word width in bits (2..32).
GAP, 1, idle cycles inserted after each word before the next word is accepted (0..15).

Ports:
clock  input  1  single system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
tx_data  input  WIDTH  word to transmit; sampled on accept
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a word this cycle
dir  input  1  0 = MSB-first, sel_out 2'b00 (shift left); 1 = LSB-first, sel_out 2'b01 (shift right); sampled on accept
ser_out  output  1  serial bit to receiver (sl_ser or sr_ser)
sel_out  output  2  receiver select: 00 shift-left, 01 shift-right, 11 hold
busy  output  1  high in SHIFT and GAP
done  output  1  one-cycle pulse after last bit edge of a word
bit_cnt  output  $clog2(WIDTH+1)  bits already shifted in current word

Behaviour:
- All outputs are registered, except tx_ready = (state == IDLE).
- Reset (synchronous, overrides everything including mid-word):
  - state = IDLE; shreg = 0; bit_cnt = 0.
  - ser_out = 0; sel_out = 2'b11; busy = 0; done = 0.
  - An aborted word is dropped and no done pulse is produced.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - sel_out = 11, ser_out = 0, tx_ready = 1.
  - Accept occurs on an edge with tx_valid = 1 and tx_ready = 1.
  - On accept: shreg <= tx_data, dir_q <= dir, bit_cnt <= 0, state <= SHIFT.
  - ser_out <= tx_data[WIDTH-1] if dir = 0, else tx_data[0].
  - sel_out <= {1'b0, dir}.
- SHIFT:
  - Each cycle presents one bit; the receiver samples it on the next rising edge.
  - At each edge: bit_cnt += 1; shreg shifts toward the output end (left for dir_q = 0, right for dir_q = 1); ser_out gets the next bit.
  - At the edge where bit_cnt == WIDTH-1 (the last bit sampled):
    - done <= 1 for exactly one cycle; sel_out <= 11; ser_out <= 0; bit_cnt <= WIDTH.
    - state <= GAP if GAP > 0, else IDLE.
  - The word occupies exactly WIDTH cycles with sel_out != 11.
- GAP:
  - sel_out = 11; counts GAP cycles, then goes to IDLE.
  - bit_cnt is cleared to 0 on entry to IDLE.
- Throughput: one word per WIDTH + GAP + 1 cycles, since the accept edge occurs in IDLE.
- tx_valid / tx_data / dir changes while busy are ignored; tx_valid may stay high continuously.
- tx_valid is not required to hold after accept. Accept happens only while tx_ready = 1.
- Bit ordering with a receiver clocked on the same clock, starting from 0:
  - dir = 0: the receiver word equals tx_data after WIDTH shift-left edges.
  - dir = 1: likewise, via shift-right edges.
- The block never drives sel_out = 10 (parallel load).

Test Plan:
- Reset, then tx_data = 8'hA5, dir = 0, tx_valid pulse -> ser_out sequence 1,0,1,0,0,1,0,1 over 8 cycles with sel_out = 00. done pulses once. A model shift-left receiver holds 8'hA5. Then sel_out = 11 for GAP = 1 cycle, and tx_ready rises.
- tx_data = 8'h3C, dir = 1 -> ser_out 0,0,1,1,1,1,0,0 (LSB first) with sel_out = 01. A shift-right receiver holds 8'h3C. bit_cnt steps 0..7 and reads 8 in the done cycle.
- tx_valid held high, words 8'h01 then 8'hFF, GAP = 0 -> second word starts exactly 9 cycles after the first accept. tx_data changes while busy are ignored. Two done pulses, 9 cycles apart.
- Reset asserted after the 4th bit of 8'hF0 -> next cycle sel_out = 11, ser_out = 0, busy = 0, no done. A new word 8'h81 is then sent cleanly.
- dir toggled and tx_data changed mid-word -> transmitted bits are unchanged from the latched word.
- GAP = 3 -> tx_ready stays low for exactly 3 cycles after done, with sel_out = 11 throughout.
